// File: rtl/eeprom_cmd_ctrl.sv
// eeprom_cmd_ctrl
// Sequences one read or write request at a time into the I2C EEPROM bit engine.
// Each phase is timed in engine bit periods (P = 2^BIT_DIV_LOG2 CLK cycles).
// The engine is re-armed with an EE_RESET pulse after every transaction.
//
// Handshake: a request transfers on the CLK edge where REQ_VALID and REQ_READY
// are both high. REQ_READY is high only in IDLE. The request fields are latched
// on that edge and may change freely afterwards. REQ_VALID is ignored in every
// other state.
module eeprom_cmd_ctrl #(
    parameter int BIT_DIV_LOG2 = 10,
    parameter int WRITE_BITS   = 32,
    parameter int READ_BITS    = 42,
    parameter int GUARD_BITS   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_RW,
    input  logic [3:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    output logic [7:0] I2C_ADDR,
    output logic [3:0] WORD_ADDR,
    inout  wire  [7:0] EEPROM_DATA,
    output logic       GO_DB,
    output logic       EE_RESET,
    output logic       BUSY,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DATA,
    output logic [2:0] STATE_DBG
);

    localparam int P  = 1 << BIT_DIV_LOG2;
    localparam int CW = BIT_DIV_LOG2 + 6;

    // Counter load values: each phase lasts (load + 1) cycles.
    localparam logic [CW-1:0] LD_SETUP = CW'(P - 1);
    localparam logic [CW-1:0] LD_START = CW'(2 * P - 1);
    localparam logic [CW-1:0] LD_RUN_W = CW'((WRITE_BITS + GUARD_BITS) * P - 1);
    localparam logic [CW-1:0] LD_RUN_R = CW'((READ_BITS + GUARD_BITS) * P - 1);
    localparam logic [CW-1:0] LD_REARM = CW'(2 * P - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_REARM   = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          op_rw;
    logic [3:0]    op_addr;
    logic [7:0]    op_wdata;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic          phase_done;
    logic          in_txn;
    logic          drive_data;

    assign phase_done = (cnt == '0);

    // Phase sequencing, request latching and read-data capture.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_rw       <= 1'b0;
            op_addr     <= 4'h0;
            op_wdata    <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            // The pulse lands on the first REARM cycle, right after CAPTURE.
            rsp_valid_q <= (state == S_CAPTURE);
            case (state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        op_rw    <= REQ_RW;
                        op_addr  <= REQ_ADDR;
                        op_wdata <= REQ_WDATA;
                        cnt      <= LD_SETUP;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_done) begin
                        cnt   <= LD_START;
                        state <= S_START;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_START: begin
                    if (phase_done) begin
                        cnt   <= op_rw ? LD_RUN_R : LD_RUN_W;
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (phase_done) begin
                        if (op_rw) begin
                            cnt   <= '0;
                            state <= S_CAPTURE;
                        end else begin
                            cnt   <= LD_REARM;
                            state <= S_REARM;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    rsp_data_q <= EEPROM_DATA;
                    cnt        <= LD_REARM;
                    state      <= S_REARM;
                end
                S_REARM: begin
                    if (phase_done) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Engine-facing outputs decoded from the current phase.
    always_comb begin
        in_txn     = 1'b0;
        drive_data = 1'b0;
        case (state)
            S_SETUP, S_START, S_RUN: begin
                in_txn     = 1'b1;
                drive_data = !op_rw;
            end
            S_CAPTURE: in_txn = 1'b1;
            default: begin
                in_txn     = 1'b0;
                drive_data = 1'b0;
            end
        endcase
    end

    assign REQ_READY   = (state == S_IDLE);
    assign BUSY        = (state != S_IDLE);
    assign GO_DB       = (state == S_START);
    assign EE_RESET    = RESET | (state == S_REARM);
    assign I2C_ADDR    = in_txn ? (op_rw ? 8'hA1 : 8'hA0) : 8'h00;
    assign WORD_ADDR   = op_addr;
    assign EEPROM_DATA = drive_data ? op_wdata : 8'bzzzz_zzzz;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign STATE_DBG   = state;

endmodule
